// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: idle
// constants and the hex-to-segment table (active low, {g,f,e,d,c,b,a}).
package sevenseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Wide enough for the largest digit count; users slice what they need.
    localparam logic [7:0] AN_OFF  = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational nibble to active-low segment pattern decoder.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_pwm.sv
// N-digit multiplexed seven-segment driver with frame-coherent shadow
// latching, leading-zero suppression, dead time at each digit change and
// PWM brightness. All display outputs are registered and active low.
module sevenseg_scan_pwm
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzs_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYC);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           p_reg;
    logic [IW-1:0]           idx_reg;
    logic [BRIGHT_W-1:0]     q_reg;

    logic [4*NUM_DIGITS-1:0] digits_sh_reg;
    logic [NUM_DIGITS-1:0]   dp_sh_reg;
    logic [NUM_DIGITS-1:0]   blank_sh_reg;
    logic                    lzs_sh_reg;
    logic [BRIGHT_W-1:0]     bright_sh_reg;

    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_start_reg;

    logic                    load;
    logic [NUM_DIGITS:0]     upper_zero;
    logic [NUM_DIGITS-1:0]   suppressed;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_seg;
    logic                    bright_ok;
    logic                    on;

    // Start of digit 0's slot is the only point where new inputs are taken.
    assign load = (p_reg == '0) && (idx_reg == '0);

    // Slot position, digit index and free-running PWM phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_reg   <= '0;
            idx_reg <= '0;
            q_reg   <= '0;
        end else begin
            q_reg <= q_reg + 1'b1;
            if (p_reg == P_LAST) begin
                p_reg   <= '0;
                idx_reg <= (idx_reg == I_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                p_reg <= p_reg + 1'b1;
            end
        end
    end

    // Shadow copy of the display inputs, refreshed once per frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits_sh_reg <= '0;
            dp_sh_reg     <= '0;
            blank_sh_reg  <= '0;
            lzs_sh_reg    <= 1'b0;
            bright_sh_reg <= '0;
        end else if (load) begin
            digits_sh_reg <= digits;
            dp_sh_reg     <= dp_in;
            blank_sh_reg  <= blank_in;
            lzs_sh_reg    <= lzs_en;
            bright_sh_reg <= brightness;
        end
    end

    // upper_zero[k]: digit k and everything above it are zero.
    assign upper_zero[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign upper_zero[gi] = (digits_sh_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
            if (gi == 0) begin : g_rightmost
                assign suppressed[gi] = 1'b0;
            end else begin : g_upper
                assign suppressed[gi] = lzs_sh_reg && upper_zero[gi];
            end
            assign an_next[gi] = !(on && (idx_reg == IW'(gi)));
        end
    endgenerate

    assign cur_digit = digits_sh_reg[{idx_reg, 2'b00} +: 4];

    sevenseg_decode u_decode (
        .nibble (cur_digit),
        .seg    (cur_seg)
    );

    // Lit decision: past the dead time, not blanked or suppressed, PWM high.
    always_comb begin
        bright_ok = (bright_sh_reg == '1) || (q_reg < bright_sh_reg);
        on        = (p_reg >= P_DEAD) && !blank_sh_reg[idx_reg]
                    && !suppressed[idx_reg] && bright_ok;
    end

    // Registered pin drivers and the frame marker.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            an_reg          <= AN_OFF[NUM_DIGITS-1:0];
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= on ? cur_seg : SEG_OFF;
            dp_reg          <= on ? ~dp_sh_reg[idx_reg] : 1'b1;
            an_reg          <= an_next;
            frame_start_reg <= load;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_sevenseg_scan_pwm.sv
// Bench for sevenseg_scan_pwm: a cycle-count-based model of the display
// predicts every output each clock, plus directed literal expectations.
module tb_sevenseg_scan_pwm;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BW = 2;
    localparam int FRAME = N * SD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lzs_en = 1'b0;
    logic [1:0]  brightness = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    sevenseg_scan_pwm #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .DEAD_CYC   (DC),
        .BRIGHT_W   (BW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lzs_en      (lzs_en),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total_cnt++;
        if (act === ex) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    endtask

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: n = clocks since reset release; slot, digit and PWM phase
    // follow directly from n.
    int          n;
    int          pm, im, qm;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank;
    logic        m_lzs;
    int          m_br;
    logic        supp, lit;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hF;
    logic        e_fs = 1'b0;
    bit          cmp_en = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n = 0; m_dig = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0; m_br = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
        end else begin
            pm = n % SD;
            im = (n / SD) % N;
            qm = n % (1 << BW);
            supp = m_lzs && (im != 0) && ((m_dig >> (4 * im)) == 16'h0);
            lit = (pm >= DC) && !m_blank[im] && !supp
                  && (m_br == (1 << BW) - 1 || qm < m_br);
            e_an = 4'hF;
            if (lit) e_an[im] = 1'b0;
            e_seg = lit ? seg_tab[m_dig[4*im +: 4]] : 7'h7F;
            e_dp = lit ? ~m_dp[im] : 1'b1;
            e_fs = (n % FRAME) == 0;
            if (e_fs) begin
                m_dig = digits; m_dp = dp_in; m_blank = blank_in;
                m_lzs = lzs_en; m_br = int'(brightness);
            end
            n++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("seg", seg, e_seg);
            chk("dp", dp, e_dp);
            chk("an", an, e_an);
            chk("frame_start", frame_start, e_fs);
        end
    end

    task automatic wait_fs();
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clock);
            if (frame_start) break;
        end
        chk("reach_frame_start", frame_start, 1);
    endtask

    task automatic wait_an(input logic [3:0] t);
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clock);
            if (an == t) break;
        end
        chk("reach_an", an, t);
    endtask

    int         lit_cnt [4];
    logic [6:0] lit_seg [4];
    int         lit_sum;

    // Tally lit clocks per digit across one frame, starting at frame_start.
    task automatic count_frame();
        lit_sum = 0;
        for (int d = 0; d < N; d++) begin lit_cnt[d] = 0; lit_seg[d] = 7'h7F; end
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clock);
            for (int d = 0; d < N; d++)
                if (!an[d]) begin lit_cnt[d]++; lit_sum++; lit_seg[d] = seg; end
        end
    endtask

    task automatic randomize_inputs();
        logic [15:0] d;
        d = 16'($urandom);
        for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 0) d[4*i +: 4] = 4'h0;
        digits = d;
        dp_in = 4'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lzs_en = 1'($urandom);
        brightness = 2'($urandom);
    endtask

    int c;

    initial begin
        reset = 1'b1;
        @(negedge clock);
        cmp_en = 1'b1;
        // Reset held with toggling inputs.
        repeat (10) begin randomize_inputs(); @(negedge clock); end
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);

        // Basic hex/dp scan.
        digits = 16'h12AF; brightness = 2'd3; lzs_en = 1'b0; dp_in = 4'b0010; blank_in = 4'h0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("fs_clock1", frame_start, 1);
        chk("dead_an", an, 4'hF);
        wait_an(4'hE); chk("d0_seg", seg, 7'b0001110); chk("d0_dp", dp, 1);
        wait_an(4'hD); chk("d1_seg", seg, 7'b0001000); chk("d1_dp", dp, 0);
        wait_an(4'hB); chk("d2_seg", seg, 7'b0100100); chk("d2_dp", dp, 1);
        wait_an(4'h7); chk("d3_seg", seg, 7'b1111001); chk("d3_dp", dp, 1);

        // Leading-zero suppression.
        lzs_en = 1'b1; digits = 16'h0050; dp_in = 4'h0;
        wait_fs(); count_frame();
        chk("lzs_d3_cnt", lit_cnt[3], 0); chk("lzs_d2_cnt", lit_cnt[2], 0);
        chk("lzs_d1_cnt", lit_cnt[1], 6); chk("lzs_d0_cnt", lit_cnt[0], 6);
        chk("lzs_d1_seg", lit_seg[1], 7'b0010010); chk("lzs_d0_seg", lit_seg[0], 7'b1000000);
        digits = 16'h0000;
        wait_fs(); count_frame();
        chk("lzs_zero_sum", lit_sum, 6); chk("lzs_zero_d0", lit_cnt[0], 6);

        // Mid-frame change stays invisible until the next frame.
        lzs_en = 1'b0; digits = 16'h12AF; brightness = 2'd3;
        wait_fs();
        wait_an(4'hB);
        digits = 16'h3456; brightness = 2'd1;
        wait_an(4'h7); chk("old_d3_seg", seg, 7'b1111001);
        wait_fs();
        wait_an(4'hE); chk("new_d0_seg", seg, 7'b0000010);

        // Brightness levels over whole frames.
        brightness = 2'd0; wait_fs(); count_frame(); chk("bright0_sum", lit_sum, 0);
        brightness = 2'd1; wait_fs(); count_frame(); chk("bright1_sum", lit_sum, 4);
        chk("bright1_d2", lit_cnt[2], 1);
        brightness = 2'd3; wait_fs(); count_frame(); chk("bright3_sum", lit_sum, 24);

        // Randomized traffic, model-checked every cycle.
        for (int k = 0; k < 20 * FRAME; k++) begin
            @(negedge clock);
            if ($urandom_range(0, 7) == 0) randomize_inputs();
        end

        // Asynchronous reset during digit 2's slot.
        digits = 16'h12AF; brightness = 2'd3; lzs_en = 1'b0; blank_in = 4'h0; dp_in = 4'h0;
        wait_fs();
        wait_an(4'hB);
        #1 reset = 1'b1;
        #1;
        chk("async_an", an, 4'hF); chk("async_seg", seg, 7'h7F);
        chk("async_dp", dp, 1); chk("async_fs", frame_start, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        c = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            c = k;
            if (an != 4'hF) break;
        end
        chk("restart_latency", c, DC + 1);
        chk("restart_an", an, 4'hE);
        repeat (2 * FRAME) @(negedge clock);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
